// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arith/shift/compare ops plus an iterative shift-add multiply.
module alu_pipe #(
    parameter int XLEN   = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [XLEN-1:0] XZERO   = {XLEN{1'b0}};

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // MUL lands in the default arm: it only reaches here when the multiplier is disabled.
    function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [SHW-1:0]  sh;
        logic [XLEN-1:0] r;
        sh = b[SHW-1:0];
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = $unsigned($signed(a) >>> sh);
            OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            default: r = XZERO;
        endcase
        return r;
    endfunction

    state_t          state_r, state_s;
    logic [XLEN-1:0] result_r, result_s;
    logic            zero_r;
    logic [XLEN-1:0] acc_r, acc_s;
    logic [XLEN-1:0] mcand_r, mcand_s;
    logic [XLEN-1:0] mplier_r, mplier_s;
    logic [SHW-1:0]  count_r, count_s;
    logic [XLEN-1:0] acc_sum_s;
    logic            in_ready_s;
    logic            accept_s;
    logic            start_mul_s;

    assign in_ready_s  = (state_r == IDLE) | ((state_r == DONE) & out_ready);
    assign accept_s    = in_valid & in_ready_s;
    assign start_mul_s = accept_s & (alu_op == OP_MUL) & (MUL_EN == 1'b1);
    assign acc_sum_s   = acc_r + (mplier_r[0] ? mcand_r : XZERO);

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r == BUSY);
    assign result    = result_r;
    assign zero      = zero_r;

    // Next-state and datapath update for the IDLE/BUSY/DONE handshake FSM.
    always_comb begin
        state_s  = state_r;
        result_s = result_r;
        acc_s    = acc_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        count_s  = count_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    if (start_mul_s) begin
                        acc_s    = XZERO;
                        mcand_s  = op_a;
                        mplier_s = op_b;
                        count_s  = CNT_ZERO;
                        state_s  = BUSY;
                    end else begin
                        result_s = alu_f(alu_op, op_a, op_b);
                        state_s  = DONE;
                    end
                end else if ((state_r == DONE) && out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            BUSY: begin
                // One multiplier bit per cycle; the last add goes straight into result.
                acc_s    = acc_sum_s;
                mcand_s  = {mcand_r[XLEN-2:0], 1'b0};
                mplier_s = {1'b0, mplier_r[XLEN-1:1]};
                if (count_r == CNT_LAST) begin
                    result_s = acc_sum_s;
                    count_s  = CNT_ZERO;
                    state_s  = DONE;
                end else begin
                    count_s  = count_r + CNT_ONE;
                    state_s  = BUSY;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            result_r <= XZERO;
            zero_r   <= 1'b1;
            acc_r    <= XZERO;
            mcand_r  <= XZERO;
            mplier_r <= XZERO;
            count_r  <= CNT_ZERO;
        end else begin
            state_r  <= state_s;
            result_r <= result_s;
            zero_r   <= (result_s == XZERO);
            acc_r    <= acc_s;
            mcand_r  <= mcand_s;
            mplier_r <= mplier_s;
            count_r  <= count_s;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios followed by randomized
// traffic with random backpressure, scored against a behavioural ALU model.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [3:0]  alu_op;
    logic [63:0] op_a, op_b, result;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, zero2, busy2;
    logic [3:0]  alu_op2;
    logic [63:0] op_a2, op_b2, result2;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] q[$];
    bit          hold_pending = 1'b0;
    logic [63:0] held_result;
    logic        held_zero;
    int          n_acc = 0;
    int          n_out = 0;
    logic [63:0] got;

    always #5 clk = ~clk;

    alu_pipe #(.XLEN(64), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    alu_pipe #(.XLEN(64), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .alu_op(alu_op2), .op_a(op_a2), .op_b(op_b2), .out_valid(out_valid2),
        .out_ready(out_ready2), .result(result2), .zero(zero2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input bit mul_en);
        logic [63:0] r;
        int          sh;
        sh = int'(b % 64);
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd6:  r = a - b;
            4'd3:  r = a ^ b;
            4'd4:  r = a << sh;
            4'd5:  r = a >> sh;
            4'd7: begin
                r = a >> sh;
                if (a[63]) for (int i = 0; i < sh; i++) r[63-i] = 1'b1;
            end
            4'd8:  r = (a[63] != b[63]) ? {63'd0, a[63]} : ((a < b) ? 64'd1 : 64'd0);
            4'd9:  r = (a < b) ? 64'd1 : 64'd0;
            4'd10: r = mul_en ? a * b : 64'd0;
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Issues one op from an idle/handing-off state and waits for its result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input int exp_lat, output logic [63:0] obs);
        logic [63:0] exp;
        int          lat;
        exp = ref_alu(op, a, b, 1'b1);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        alu_op = op; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            chk({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
            in_valid = 1'b1; alu_op = 4'd2; op_a = {$urandom, $urandom}; op_b = 64'd1;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_zero"}, 64'(zero), 64'(exp == 64'd0));
        obs = result;
    endtask

    // One cycle of random traffic: scores handoffs against the queue of accepted ops.
    task automatic step(input bit allow_in);
        logic [3:0] op;
        if (hold_pending) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_result", result, held_result);
            chk("hold_zero", 64'(zero), 64'(held_zero));
        end
        op = 4'($urandom_range(0, 15));
        if (op == 4'd10 && $urandom_range(0, 3) != 0) op = 4'd2;
        alu_op = op; op_a = rand64(); op_b = rand64();
        in_valid  = allow_in && ($urandom_range(0, 1) == 1);
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (out_valid && out_ready) begin
            chk("no_dup_handoff", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                chk("rand_result", result, q[0]);
                chk("rand_zero", 64'(zero), 64'(q[0] == 64'd0));
                void'(q.pop_front());
            end
            n_out++;
        end
        hold_pending = out_valid && !out_ready;
        held_result  = result;
        held_zero    = zero;
        if (in_valid && in_ready) begin
            q.push_back(ref_alu(op, op_a, op_b, 1'b1));
            n_acc++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; alu_op = 4'd0; op_a = 64'd0; op_b = 64'd0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; alu_op2 = 4'd0; op_a2 = 64'd0; op_b2 = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        run_op("add_wrap", 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, got);
        chk("add_wrap_const", got, 64'd0);
        chk("add_wrap_zero1", 64'(zero), 64'd1);

        run_op("sra", 4'd7, 64'h8000_0000_0000_0000, 64'h43, 1, got);
        chk("sra_const", got, 64'hF000_0000_0000_0000);
        run_op("slt", 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, got);
        chk("slt_const", got, 64'd1);
        run_op("sltu", 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, got);
        chk("sltu_const", got, 64'd0);

        run_op("mul", 4'd10, 64'h1_0000_0001, 64'd3, 65, got);
        chk("mul_const", got, 64'h3_0000_0003);

        run_op("b2b_and", 4'd0, 64'd5, 64'd7, 1, got);
        chk("b2b_and_const", got, 64'd5);
        run_op("b2b_or", 4'd1, 64'd5, 64'd7, 1, got);
        chk("b2b_or_const", got, 64'd7);
        run_op("b2b_sub", 4'd6, 64'd5, 64'd7, 1, got);
        chk("b2b_sub_const", got, 64'hFFFF_FFFF_FFFF_FFFE);

        run_op("bp_or", 4'd1, 64'hF0, 64'h0F, 1, got);
        out_ready = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_result", result, 64'hFF);
            chk("bp_zero", 64'(zero), 64'd0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("bp_single_handoff", 64'(out_valid), 64'd0);

        alu_op = 4'd10; op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("midmul_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midmul_rst_out_valid", 64'(out_valid), 64'd0);
        chk("midmul_rst_busy", 64'(busy), 64'd0);
        chk("midmul_rst_result", result, 64'd0);
        chk("midmul_rst_zero", 64'(zero), 64'd1);
        chk("midmul_rst_in_ready", 64'(in_ready), 64'd1);
        run_op("post_rst_add", 4'd2, 64'd2, 64'd2, 1, got);
        chk("post_rst_add_const", got, 64'd4);

        alu_op2 = 4'd10; op_a2 = 64'd5; op_b2 = 64'd7; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        chk("nomul_out_valid", 64'(out_valid2), 64'd1);
        chk("nomul_result", result2, 64'd0);
        chk("nomul_zero", 64'(zero2), 64'd1);
        chk("nomul_busy", 64'(busy2), 64'd0);

        chk("pre_random_idle", 64'(out_valid), 64'd0);
        repeat (600) step(1'b1);
        repeat (200) step(1'b0);
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("accept_vs_handoff", 64'(n_out), 64'(n_acc));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
